// File: rtl/ej32_pkg.sv
// Shared eJ32 types: opcodes, stack ops, fetch FSM states and per-opcode length tables.
// Pure declarations and combinational helper functions; no state.
package ej32_pkg;

  typedef enum logic [7:0] {
    nop           = 8'h00,
    iconst_0      = 8'h03,
    dup           = 8'h59,
    iadd          = 8'h60,
    isub          = 8'h64,
    ifeq          = 8'h99,
    ifne          = 8'h9A,
    iflt          = 8'h9B,
    ifge          = 8'h9C,
    ifgt          = 8'h9D,
    ifle          = 8'h9E,
    if_icmpeq     = 8'h9F,
    if_icmpne     = 8'hA0,
    if_icmplt     = 8'hA1,
    if_icmpge     = 8'hA2,
    if_icmpgt     = 8'hA3,
    if_icmple     = 8'hA4,
    goto          = 8'hA7,
    jsr           = 8'hA8,
    invokevirtual = 8'hB6,
    donext        = 8'hCB
  } opcode_t;

  typedef enum logic [1:0] {
    sNONE,
    sPUSH,
    sPOP
  } stack_op;

  typedef enum logic [1:0] {
    sIDLE,
    sFETCH,
    sEXEC
  } fetch_state_t;

  // Cycles spent in sEXEC per opcode (1..8); anything not listed is single-cycle.
  function automatic logic [3:0] op_len(input opcode_t op);
    case (op)
      goto, ifeq, ifne, iflt, ifge, ifgt, ifle,
      if_icmpeq, if_icmpne, if_icmplt, if_icmpge, if_icmpgt, if_icmple,
      invokevirtual, donext:  op_len = 4'd3;
      jsr:                    op_len = 4'd4;
      default:                op_len = 4'd1;
    endcase
  endfunction

  // Inline operand bytes consumed, i.e. phases in which p advances.
  function automatic logic [2:0] op_bytes(input opcode_t op);
    case (op)
      goto, ifeq, ifne, iflt, ifge, ifgt, ifle,
      if_icmpeq, if_icmpne, if_icmplt, if_icmpge, if_icmpgt, if_icmple,
      invokevirtual, donext, jsr: op_bytes = 3'd2;
      default:                    op_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/ej32_oplen.sv
// Combinational opcode table lookup: last phase index (N-1) and operand byte count.
// Zero latency, no flow control.
module ej32_oplen
  import ej32_pkg::*;
(
  input  opcode_t    code_i,
  output logic [2:0] last_o,
  output logic [2:0] bytes_o
);

  logic [3:0] len;

  always_comb begin
    len     = op_len(code_i);
    last_o  = (len == 4'd0) ? 3'd0 : 3'(len - 4'd1);
    bytes_o = op_bytes(code_i);
  end

endmodule

// File: rtl/ej32_fetch.sv
// eJ32 instruction fetch: walks the byte stream, tracks opcode/phase, applies branch redirects.
// Opcode latched one edge after its byte is presented; en=0 freezes all state.
module ej32_fetch
  import ej32_pkg::*;
#(
  parameter int DSZ = 32,
  parameter int ASZ = 17
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [7:0]     mem_data,
  input  logic           br_psel_i,
  input  logic [ASZ-1:0] br_p_i,
  output logic [ASZ-1:0] p_o,
  output opcode_t        code_o,
  output logic [2:0]     phase_o,
  output logic [7:0]     data_o,
  output logic           fetch_o
);

  if (DSZ < 8) begin : g_dsz_chk
    $error("ej32_fetch: DSZ must be at least one byte wide");
  end

  fetch_state_t   state_q, state_d;
  logic [ASZ-1:0] p_q, p_d;
  opcode_t        code_q, code_d;
  logic [2:0]     phase_q, phase_d;
  logic [2:0]     last;
  logic [2:0]     bytes;
  logic           exec_last;

  ej32_oplen u_oplen (
    .code_i  (code_q),
    .last_o  (last),
    .bytes_o (bytes)
  );

  assign exec_last = (phase_q >= last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= sIDLE;
      p_q     <= '0;
      code_q  <= nop;
      phase_q <= '0;
    end else if (en) begin
      state_q <= state_d;
      p_q     <= p_d;
      code_q  <= code_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    code_d  = code_q;
    phase_d = phase_q;
    unique case (state_q)
      sIDLE: state_d = sFETCH;
      sFETCH: begin
        code_d  = opcode_t'(mem_data);
        p_d     = p_q + ASZ'(1);
        phase_d = 3'd0;
        state_d = sEXEC;
      end
      sEXEC: begin
        // A redirect wins over both operand stepping and the next-opcode latch.
        if (br_psel_i) begin
          p_d     = br_p_i;
          phase_d = 3'd0;
          code_d  = nop;
          state_d = sFETCH;
        end else if (!exec_last) begin
          phase_d = phase_q + 3'd1;
          if (phase_q < bytes) p_d = p_q + ASZ'(1);
        end else begin
          code_d  = opcode_t'(mem_data);
          phase_d = 3'd0;
          p_d     = p_q + ASZ'(1);
        end
      end
      default: state_d = sIDLE;
    endcase
  end

  always_comb begin
    p_o     = p_q;
    code_o  = code_q;
    phase_o = phase_q;
    data_o  = mem_data;
    fetch_o = en && ((state_q == sFETCH) ||
                     ((state_q == sEXEC) && !br_psel_i && exec_last));
  end

endmodule

// File: tb/tb_ej32_fetch.sv
// Table-driven bench for ej32_fetch with a byte memory model and an expected-value queue.
module tb_ej32_fetch;
  import ej32_pkg::*;

  localparam int ASZ = 17;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic           br_psel_i = 1'b0;
  logic [ASZ-1:0] br_p_i = '0;
  logic [7:0]     mem_data;
  logic [ASZ-1:0] p_o;
  opcode_t        code_o;
  logic [2:0]     phase_o;
  logic [7:0]     data_o;
  logic           fetch_o;

  logic [7:0] mem [0:(1<<ASZ)-1];
  assign mem_data = mem[p_o];

  always #5 clk = ~clk;

  ej32_fetch #(.DSZ(32), .ASZ(ASZ)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mem_data  (mem_data),
    .br_psel_i (br_psel_i),
    .br_p_i    (br_p_i),
    .p_o       (p_o),
    .code_o    (code_o),
    .phase_o   (phase_o),
    .data_o    (data_o),
    .fetch_o   (fetch_o)
  );

  typedef struct {
    logic           en;
    logic           br;
    logic [ASZ-1:0] bp;
    logic [ASZ-1:0] p;
    logic [7:0]     code;
    logic [2:0]     ph;
    logic           f;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic e, input logic b, input int bpv,
                              input int pv, input int cv, input int phv, input logic fv);
    vec_t v;
    v.en = e; v.br = b; v.bp = ASZ'(bpv);
    v.p = ASZ'(pv); v.code = 8'(cv); v.ph = 3'(phv); v.f = fv;
    return v;
  endfunction

  // Drive one cycle's inputs, queue its expectation, compare mid-cycle, advance past the edge.
  task automatic step(input vec_t v, input int idx);
    vec_t e;
    en = v.en; br_psel_i = v.br; br_p_i = v.bp;
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    chk($sformatf("v%0d.p", idx),     32'(p_o),     32'(e.p));
    chk($sformatf("v%0d.code", idx),  32'(code_o),  32'(e.code));
    chk($sformatf("v%0d.phase", idx), 32'(phase_o), 32'(e.ph));
    chk($sformatf("v%0d.fetch", idx), 32'(fetch_o), 32'(e.f));
    chk($sformatf("v%0d.data", idx),  32'(data_o),  32'(mem[e.p]));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_first;
    for (int i = 0; i < (1 << ASZ); i++) mem[i] = 8'h00;
    mem[0] = 8'h60; mem[1] = 8'h00; mem[2] = 8'h60;
    mem[17'h10] = 8'hA7; mem[17'h11] = 8'h00; mem[17'h12] = 8'h20;
    mem[17'h20] = 8'h60;
    mem[17'h40] = 8'h99; mem[17'h41] = 8'h00; mem[17'h42] = 8'h05; mem[17'h43] = 8'h60;
    mem[17'h100] = 8'hA8; mem[17'h101] = 8'h00; mem[17'h102] = 8'h10; mem[17'h103] = 8'h60;

    //          en br bp        p        code  ph f
    vecs.push_back(mk(0, 0, 0,        0,       8'h00, 0, 0)); // en=0 holds sIDLE
    vecs.push_back(mk(1, 0, 0,        0,       8'h00, 0, 0)); // sIDLE
    vecs.push_back(mk(1, 0, 0,        0,       8'h00, 0, 1)); // sFETCH
    vecs.push_back(mk(1, 0, 0,        1,       8'h60, 0, 1));
    vecs.push_back(mk(1, 0, 0,        2,       8'h00, 0, 1));
    vecs.push_back(mk(1, 0, 0,        3,       8'h60, 0, 1));
    vecs.push_back(mk(1, 1, 'h10,     4,       8'h00, 0, 0)); // redirect beats fetch
    vecs.push_back(mk(1, 1, 'h77,     'h10,    8'h00, 0, 1)); // br ignored in sFETCH
    vecs.push_back(mk(1, 0, 0,        'h11,    8'hA7, 0, 0)); // goto
    vecs.push_back(mk(1, 0, 0,        'h12,    8'hA7, 1, 0));
    vecs.push_back(mk(1, 1, 'h20,     'h13,    8'hA7, 2, 0)); // taken at phase 2
    vecs.push_back(mk(1, 0, 0,        'h20,    8'h00, 0, 1));
    vecs.push_back(mk(1, 1, 'h40,     'h21,    8'h60, 0, 0));
    vecs.push_back(mk(1, 0, 0,        'h40,    8'h00, 0, 1));
    vecs.push_back(mk(1, 0, 0,        'h41,    8'h99, 0, 0)); // ifeq not taken
    vecs.push_back(mk(1, 0, 0,        'h42,    8'h99, 1, 0));
    vecs.push_back(mk(1, 0, 0,        'h43,    8'h99, 2, 1));
    vecs.push_back(mk(1, 1, 'h100,    'h44,    8'h60, 0, 0)); // no bubble after ifeq
    vecs.push_back(mk(0, 0, 0,        'h100,   8'h00, 0, 0)); // stalled sFETCH: no fetch
    vecs.push_back(mk(1, 0, 0,        'h100,   8'h00, 0, 1));
    vecs.push_back(mk(1, 0, 0,        'h101,   8'hA8, 0, 0)); // jsr
    vecs.push_back(mk(0, 1, 'h55,     'h102,   8'hA8, 1, 0)); // stall, redirect lost
    vecs.push_back(mk(0, 0, 0,        'h102,   8'hA8, 1, 0));
    vecs.push_back(mk(0, 0, 0,        'h102,   8'hA8, 1, 0));
    vecs.push_back(mk(1, 0, 0,        'h102,   8'hA8, 1, 0));
    vecs.push_back(mk(1, 0, 0,        'h103,   8'hA8, 2, 0));
    vecs.push_back(mk(1, 0, 0,        'h103,   8'hA8, 3, 1)); // p holds in phase 3
    vecs.push_back(mk(1, 1, 'h1FFFF,  'h104,   8'h60, 0, 0));
    vecs.push_back(mk(1, 0, 0,        'h1FFFF, 8'h00, 0, 1));
    vecs.push_back(mk(1, 0, 0,        0,       8'h00, 0, 1)); // address wrap
    vecs.push_back(mk(1, 0, 0,        1,       8'h60, 0, 1));
    vecs.push_back(mk(1, 1, 'h10,     2,       8'h00, 0, 0));
    vecs.push_back(mk(1, 0, 0,        'h10,    8'h00, 0, 1));
    vecs.push_back(mk(1, 0, 0,        'h11,    8'hA7, 0, 0));
    n_first = vecs.size();
    vecs.push_back(mk(1, 0, 0,        0,       8'h00, 0, 0)); // after mid-goto reset
    vecs.push_back(mk(1, 0, 0,        0,       8'h00, 0, 1));
    vecs.push_back(mk(1, 0, 0,        1,       8'h60, 0, 1));

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b0;
    #1;
    chk("rst_async.p", 32'(p_o), 32'h0);
    chk("rst_async.code", 32'(code_o), 32'h0);
    chk("rst_async.fetch", 32'(fetch_o), 32'h0);
    en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_held.p", 32'(p_o), 32'h0);
    chk("rst_held.fetch", 32'(fetch_o), 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < n_first; i++) step(vecs[i], i);

    // Now in goto phase 1 at p=0x12; pull reset mid-cycle.
    en = 1'b1; br_psel_i = 1'b0;
    chk("mid_goto.phase", 32'(phase_o), 32'h1);
    chk("mid_goto.p", 32'(p_o), 32'h12);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid.p", 32'(p_o), 32'h0);
    chk("rst_mid.code", 32'(code_o), 32'h0);
    chk("rst_mid.phase", 32'(phase_o), 32'h0);
    chk("rst_mid.fetch", 32'(fetch_o), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    for (int i = n_first; i < vecs.size(); i++) step(vecs[i], i);

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
